fetch_unit: RTL

//  Instruction fetch stage of the single-cycle RISC-V core: owns the PC, fetches from instruction

---
 rtl/riscv_defs_pkg.sv | 29 ++
 rtl/fetch_unit_next_pc_gen.sv | 35 +++
 rtl/fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V core definitions: data width, canonical NOP, base opcodes
// and the fetch-stage FSM state encoding.
package riscv_defs;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Fetch FSM: issue request, wait for data, hold for retire, halted on fault
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Next-PC selection: sequential, pc-relative (branch/jal) or register
// target (jalr, LSB cleared). Flags a redirect target that is not word aligned.
module next_pc_gen
    import riscv_defs::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            redirect,
    input  logic            jalr_sel,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] pc_reg;

    // All adds are modulo 2^32; wrap-around is intentionally silent.
    assign pc_seq = pc + 32'd4;
    assign pc_rel = pc + imm_ext;
    assign pc_reg = alu_result & ~32'd1;

    // Select the target, then flag a half-word-aligned redirect
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_pc    = pc_seq;
        misaligned = 1'b0;
        if (redirect) begin
            next_pc    = jalr_sel ? pc_reg : pc_rel;
            misaligned = next_pc[1];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready memory
// handshake, holds the word in the instruction register until the core
// retires it, then advances to the computed next PC.
module fetch_unit
    import riscv_defs::*;
#(
    // Must be 4-byte aligned.
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect,
    input  logic            jalr_sel,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic            misalign_err,
    output logic [XLEN-1:0] instret
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            started;     // low for the first cycle after reset release
    logic            retire;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_gen u_next_pc_gen (
        .pc         (pc),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .redirect   (redirect),
        .jalr_sel   (jalr_sel),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign retire    = (state == S_HOLD) && instr_ready;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= S_REQ;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_REQ:  if (started && imem_req_ready) state_next = S_WAIT;
            S_WAIT: if (imem_rsp_valid)            state_next = S_HOLD;
            S_HOLD: if (instr_ready)               state_next = misaligned ? S_HALT : S_REQ;
            S_HALT:                                state_next = S_HALT;
            default:                               state_next = S_REQ;
        endcase
    end

    // FSM outputs; the request is suppressed for one cycle after reset release
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        misalign_err   = 1'b0;
        case (state)
            S_REQ:   imem_req_valid = started;
            S_HOLD:  instr_valid    = 1'b1;
            S_HALT:  misalign_err   = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction register, retire counter and start-up flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            instret <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (state == S_WAIT && imem_rsp_valid) begin
                instr <= imem_rdata;
            end
            // A faulting redirect still retires; pc keeps the offending target.
            if (retire) begin
                instret <= instret + 32'd1;
                pc      <= next_pc;
            end
        end
    end

endmodule
